cla_4bit: RTL and testbench
===========================

CLA_4BIT -- requirements
Module: cla_4bit

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 4 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  qualifies a, b, cin for capture on the current rising edge.
REQ-005 a  input  4  addend A, unsigned or two's complement.
REQ-006 b  input  4  addend B, unsigned or two's complement.
REQ-007 cin  input  1  carry-in.
REQ-008 out_valid  output  1  high for one cycle per registered result.
REQ-009 sum  output  4  registered sum bits, (a+b+cin) mod 16.
REQ-010 cout  output  1  registered carry-out, bit 4 of a+b+cin.
REQ-011 ovf  output  1  registered signed overflow.
REQ-012 pg  output  1  registered group propagate.
REQ-013 gg  output  1  registered group generate.

Function
REQ-014 Bit terms SHALL be p[i]=a[i]^b[i] and g[i]=a[i]&b[i] for i=0..3.
REQ-015 Carries SHALL be computed by two-level lookahead, with no ripple chain:
- c0 = cin
- c1 = g0|p0c0
- c2 = g1|p1g0|p1p0c0
- c3 = g2|p2g1|p2p1g0|p2p1p0c0
- c4 = g3|p3g2|p3p2g1|p3p2p1g0|p3p2p1p0c0
REQ-016 sum[i] SHALL equal p[i]^c[i], and cout SHALL equal c4.
REQ-017 pg SHALL equal p3&p2&p1&p0.
REQ-018 gg SHALL equal g3|p3g2|p3p2g1|p3p2p1g0, independent of cin.
REQ-019 ovf SHALL equal c4^c3, which is high when the signed result is out of the range -8..7.
REQ-020 Latency SHALL be exactly 1 cycle: the result of inputs sampled with in_valid=1 SHALL appear on the next rising edge with out_valid=1.
REQ-021 When in_valid=0 at a rising edge, out_valid SHALL go 0 and sum, cout, ovf, pg, gg SHALL hold their previous values.
REQ-022 Back-to-back in_valid=1 cycles SHALL produce one result per cycle with no stalls or backpressure.
REQ-023 Wrap-around SHALL be modulo 16, with the lost bit reported on cout; for example, 1111+0000 with cin=1 gives sum=0000 and cout=1.
REQ-024 Outputs SHALL be a pure function of the last captured operands and SHALL contain no combinational path from the inputs.

Reset
REQ-025 While rst=1, out_valid, sum, cout, ovf, pg and gg SHALL be 0 immediately, without waiting for clk.
REQ-026 An in_valid capture coinciding with rst=1 SHALL be discarded.
REQ-027 Reset asserted mid-stream SHALL drop any pending result; the first capture after rst deasserts SHALL produce a valid result one cycle later.

Verification
REQ-028 a=0110, b=0011, cin=0, in_valid=1 -> next cycle: sum=1001, cout=0, ovf=1, pg=0, gg=0, out_valid=1.
REQ-029 a=1100, b=1010, cin=0 -> sum=0110, cout=1, ovf=1, pg=0, gg=1.
REQ-030 a=1111, b=0001, cin=0 -> sum=0000, cout=1, ovf=0, pg=0, gg=1.
REQ-031 a=1001, b=1001, cin=0 -> sum=0010, cout=1, ovf=1, gg=1.
REQ-032 a=1010, b=0101, cin=1 -> sum=0000, cout=1, pg=1, gg=0, ovf=0; with cin=0 the result is sum=1111, cout=0.
REQ-033 Assert rst between clock edges with out_valid=1 -> all outputs 0 at once; in_valid=0 for 3 cycles -> outputs hold; exhaustive sweep of all 512 combinations of a, b, cin -> {cout,sum} equals a+b+cin every time.

Source files
------------

// File: rtl/cla_4bit.sv
// cla_4bit: registered 4-bit carry-lookahead adder.
//
// Captures a, b and cin on a rising clock edge whenever in_valid is high and
// presents the sum, carry-out, signed overflow and group propagate/generate
// one cycle later with out_valid high for that single cycle. When in_valid is
// low, out_valid drops and the result registers keep their previous values.
//
// Ports:
//   clk       in   1  clock, all state updates on the rising edge
//   rst       in   1  asynchronous active-high reset, clears every output
//   in_valid  in   1  qualifies a, b, cin for capture
//   a, b      in   4  addends (unsigned or two's complement)
//   cin       in   1  carry-in
//   out_valid out  1  high for one cycle per registered result
//   sum       out  4  (a+b+cin) mod 16
//   cout      out  1  bit 4 of a+b+cin
//   ovf       out  1  signed overflow (c4 ^ c3)
//   pg        out  1  group propagate
//   gg        out  1  group generate (independent of cin)
module cla_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       out_valid,
  output logic [3:0] sum,
  output logic       cout,
  output logic       ovf,
  output logic       pg,
  output logic       gg
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;
  logic [3:0] w_sum;
  logic       w_pg;
  logic       w_gg;
  logic       w_ovf;

  logic       r_outValid;
  logic [3:0] r_sum;
  logic       r_cout;
  logic       r_ovf;
  logic       r_pg;
  logic       r_gg;

  // Per-bit propagate and generate terms.
  assign w_p = a ^ b;
  assign w_g = a & b;

  // Every carry is a flat sum of products of the bit terms and cin, so no
  // carry depends on another carry and there is no ripple chain.
  always_comb begin
    w_c[0] = cin;
    w_c[1] = w_g[0]
           | (w_p[0] & cin);
    w_c[2] = w_g[1]
           | (w_p[1] & w_g[0])
           | (w_p[1] & w_p[0] & cin);
    w_c[3] = w_g[2]
           | (w_p[2] & w_g[1])
           | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & cin);
    w_c[4] = w_g[3]
           | (w_p[3] & w_g[2])
           | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
  end

  assign w_sum = w_p ^ w_c[3:0];
  assign w_pg  = &w_p;
  // Group generate is the carry-out with cin forced to zero.
  assign w_gg  = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  // Carries into and out of the sign bit disagree exactly on signed overflow.
  assign w_ovf = w_c[4] ^ w_c[3];

  // Result registers load only on a valid capture; out_valid tracks in_valid
  // so it is a single-cycle strobe per result. Reset clears everything,
  // which also discards any capture that coincides with reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_sum      <= 4'd0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_pg       <= 1'b0;
      r_gg       <= 1'b0;
    end else begin
      r_outValid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_c[4];
        r_ovf  <= w_ovf;
        r_pg   <= w_pg;
        r_gg   <= w_gg;
      end
    end
  end

  assign out_valid = r_outValid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign pg        = r_pg;
  assign gg        = r_gg;

endmodule

// File: tb/tb_cla_4bit.sv
// tb_cla_4bit: self-checking bench for cla_4bit.
//
// Drives directed vectors, reset scenarios, an idle-hold check, an exhaustive
// back-to-back sweep and a randomized stream, comparing every registered
// result with an arithmetic reference model.
module tb_cla_4bit;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic [3:0] opA;
  logic [3:0] opB;
  logic       carryIn;
  logic       outValid;
  logic [3:0] sumOut;
  logic       coutOut;
  logic       ovfOut;
  logic       pgOut;
  logic       ggOut;

  int total = 0;
  int bad   = 0;

  // Expected output vector: {out_valid, cout, ovf, pg, gg, sum[3:0]}.
  logic [8:0] expState;
  logic [8:0] obsVec;

  assign obsVec = {outValid, coutOut, ovfOut, pgOut, ggOut, sumOut};

  cla_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .a         (opA),
    .b         (opB),
    .cin       (carryIn),
    .out_valid (outValid),
    .sum       (sumOut),
    .cout      (coutOut),
    .ovf       (ovfOut),
    .pg        (pgOut),
    .gg        (ggOut)
  );

  // 10-unit clock period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from plain integer arithmetic rather than gate
  // equations: the carry comes from the full sum, overflow from the signed
  // range, pg from all bits differing and gg from the carry of a+b alone.
  function automatic logic [8:0] refModel(input logic [3:0] ia,
                                          input logic [3:0] ib,
                                          input logic ic);
    int unsignedSum;
    int signedSum;
    logic rCout, rOvf, rPg, rGg;
    logic [3:0] rSum;
    unsignedSum = int'(ia) + int'(ib) + int'(ic);
    signedSum   = int'($signed(ia)) + int'($signed(ib)) + int'(ic);
    rSum  = 4'(unsignedSum % 16);
    rCout = (unsignedSum >= 16);
    rOvf  = (signedSum > 7) || (signedSum < -8);
    rPg   = ((ia ^ ib) == 4'hF);
    rGg   = ((int'(ia) + int'(ib)) >= 16);
    return {1'b1, rCout, rOvf, rPg, rGg, rSum};
  endfunction

  // Drives one cycle of stimulus on the falling edge, lets the rising edge
  // capture it, updates the expected state and leaves time 1 unit after the
  // edge for sampling.
  task automatic applyStimulus(input logic [3:0] ia, input logic [3:0] ib,
                               input logic ic, input logic iv);
    @(negedge clk);
    opA     = ia;
    opB     = ib;
    carryIn = ic;
    inValid = iv;
    @(posedge clk);
    if (rst)
      expState = 9'd0;
    else if (iv)
      expState = refModel(ia, ib, ic);
    else
      expState = {1'b0, expState[7:0]};
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [8:0] observed,
                             input logic [8:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b (vld,cout,ovf,pg,gg,sum)",
               tag, observed, expected);
    end
  endtask

  initial begin
    rst      = 1'b1;
    inValid  = 1'b1;
    opA      = 4'hF;
    opB      = 4'h1;
    carryIn  = 1'b1;
    expState = 9'd0;

    // Reset state, then a capture attempted while reset is held.
    #2;
    checkOutput("resetState", obsVec, 9'd0);
    @(posedge clk);
    #1;
    checkOutput("captureInReset", obsVec, 9'd0);
    @(negedge clk);
    rst     = 1'b0;
    inValid = 1'b0;

    // Directed vectors with spec-given results.
    applyStimulus(4'b0110, 4'b0011, 1'b0, 1'b1);
    checkOutput("vec0110p0011", obsVec, 9'b1_0_1_0_0_1001);
    applyStimulus(4'b1100, 4'b1010, 1'b0, 1'b1);
    checkOutput("vec1100p1010", obsVec, 9'b1_1_1_0_1_0110);
    applyStimulus(4'b1111, 4'b0001, 1'b0, 1'b1);
    checkOutput("vec1111p0001", obsVec, 9'b1_1_0_0_1_0000);
    applyStimulus(4'b1001, 4'b1001, 1'b0, 1'b1);
    checkOutput("vec1001p1001", obsVec, 9'b1_1_1_0_1_0010);
    applyStimulus(4'b1010, 4'b0101, 1'b1, 1'b1);
    checkOutput("vec1010p0101c1", obsVec, 9'b1_1_0_1_0_0000);
    applyStimulus(4'b1010, 4'b0101, 1'b0, 1'b1);
    checkOutput("vec1010p0101c0", obsVec, 9'b1_0_0_1_0_1111);
    applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b1);
    checkOutput("wrap1111c1", obsVec, 9'b1_1_0_1_0_0000);

    // Idle cycles: out_valid drops, result fields hold.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'(i + 3), 4'(i + 7), 1'b1, 1'b0);
      checkOutput("idleHold", obsVec, 9'b0_1_0_1_0_0000);
    end

    // Reset asserted between edges while a result is valid.
    applyStimulus(4'b0110, 4'b0011, 1'b0, 1'b1);
    checkOutput("preMidReset", obsVec, expState);
    #2;
    rst = 1'b1;
    #1;
    expState = 9'd0;
    checkOutput("midResetAsync", obsVec, 9'd0);
    applyStimulus(4'b0101, 4'b0101, 1'b0, 1'b1);
    checkOutput("midResetDiscard", obsVec, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b0111, 4'b0001, 1'b0, 1'b1);
    checkOutput("firstAfterReset", obsVec, refModel(4'b0111, 4'b0001, 1'b0));

    // Exhaustive back-to-back sweep of every a, b, cin combination.
    for (int i = 0; i < 512; i++) begin
      applyStimulus(4'(i[8:5]), 4'(i[4:1]), i[0], 1'b1);
      checkOutput("sweep", obsVec, expState);
    end

    // Randomized stream with random gaps in in_valid.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      checkOutput("random", obsVec, expState);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
